// File: rtl/mem_arbiter_pkg.sv
// Shared decode types for the memory arbiter: ALU/memory op codes, arbiter FSM
// states, the default ack timeout and small op-classification helpers.
package mem_arbiter_pkg;

  typedef enum logic [3:0] {
    ADD_OP,
    SUB_OP,
    AND_OP,
    OR_OP,
    XOR_OP,
    SLT_OP,
    SLL_OP,
    SRL_OP,
    LW_OP,
    LB_OP,
    SW_OP,
    SB_OP
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IF,
    BUSY_LS,
    RESP
  } mem_state_t;

  localparam int MEM_MAX_WAIT = 255;

  function automatic logic is_store_op(alu_op_t op);
    return (op == SW_OP) || (op == SB_OP);
  endfunction

  function automatic logic is_byte_op(alu_op_t op);
    return (op == LB_OP) || (op == SB_OP);
  endfunction

  // Word accesses must be word aligned; byte accesses may use any lane.
  function automatic logic ls_access_ok(alu_op_t op, logic [1:0] lane);
    case (op)
      LB_OP, SB_OP: return 1'b1;
      LW_OP, SW_OP: return lane == 2'b00;
      default:      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the CPU view and the 32-bit memory bus:
// byte enables, store-byte replication and load-byte sign extension.
module mem_lane_align
  import mem_arbiter_pkg::*;
(
  input  alu_op_t     op,
  input  logic [1:0]  lane,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  be,
  output logic [31:0] mem_wdata,
  output logic [31:0] load_data
);

  logic [7:0] byte_sel;

  always_comb begin
    be        = 4'b1111;
    mem_wdata = store_data;
    load_data = mem_rdata;
    byte_sel  = mem_rdata[{lane, 3'b000} +: 8];
    if (is_byte_op(op)) begin
      be        = 4'b0001 << lane;
      mem_wdata = {4{store_data[7:0]}};
      load_data = {{24{byte_sel[7]}}, byte_sel};
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single memory port shared by instruction fetch and load/store, load/store
// having priority; misaligned or unknown accesses and ack timeouts answer with err.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = MEM_MAX_WAIT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  output logic        if_err,
  input  logic        ls_req,
  input  alu_op_t     ls_op,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic [31:0] ls_rdata,
  output logic        ls_ack,
  output logic        ls_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  mem_state_t    state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          ls_owner_q, ls_owner_d;
  alu_op_t       op_q, op_d;
  logic [1:0]    lane_q, lane_d;

  logic          mem_req_d, mem_we_d;
  logic [3:0]    mem_be_d;
  logic [31:0]   mem_addr_d, mem_wdata_d;
  logic          if_ack_d, if_err_d, ls_ack_d, ls_err_d;
  logic [31:0]   if_rdata_d, ls_rdata_d;

  logic          rsp_valid, rsp_err;
  logic [31:0]   rsp_rdata;

  alu_op_t       align_op;
  logic [1:0]    align_lane;
  logic [3:0]    align_be;
  logic [31:0]   align_wdata, align_rdata;

  // The aligner sees the incoming load/store while idle and the latched access otherwise.
  assign align_op   = (state_q == IDLE) ? ls_op : op_q;
  assign align_lane = (state_q == IDLE) ? ls_addr[1:0] : lane_q;

  mem_lane_align u_align (
    .op         (align_op),
    .lane       (align_lane),
    .store_data (ls_wdata),
    .mem_rdata  (mem_rdata),
    .be         (align_be),
    .mem_wdata  (align_wdata),
    .load_data  (align_rdata)
  );

  assign stall = (if_req & ~if_ack) | (ls_req & ~ls_ack);

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    ls_owner_d  = ls_owner_q;
    op_d        = op_q;
    lane_d      = lane_q;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_be_d    = mem_be;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    if_ack_d    = 1'b0;
    if_err_d    = 1'b0;
    if_rdata_d  = '0;
    ls_ack_d    = 1'b0;
    ls_err_d    = 1'b0;
    ls_rdata_d  = '0;
    rsp_valid   = 1'b0;
    rsp_err     = 1'b0;
    rsp_rdata   = '0;

    case (state_q)
      IDLE: begin
        wait_d = '0;
        if (ls_req) begin
          ls_owner_d = 1'b1;
          op_d       = ls_op;
          lane_d     = ls_addr[1:0];
          if (ls_access_ok(ls_op, ls_addr[1:0])) begin
            state_d     = BUSY_LS;
            mem_req_d   = 1'b1;
            mem_we_d    = is_store_op(ls_op);
            mem_be_d    = align_be;
            mem_addr_d  = {ls_addr[31:2], 2'b00};
            mem_wdata_d = is_store_op(ls_op) ? align_wdata : '0;
          end else begin
            state_d   = RESP;
            rsp_valid = 1'b1;
            rsp_err   = 1'b1;
          end
        end else if (if_req) begin
          ls_owner_d = 1'b0;
          op_d       = LW_OP;
          lane_d     = 2'b00;
          if (if_addr[1:0] == 2'b00) begin
            state_d     = BUSY_IF;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_be_d    = 4'b1111;
            mem_addr_d  = {if_addr[31:2], 2'b00};
            mem_wdata_d = '0;
          end else begin
            state_d   = RESP;
            rsp_valid = 1'b1;
            rsp_err   = 1'b1;
          end
        end
      end

      BUSY_IF, BUSY_LS: begin
        if (mem_ack) begin
          state_d   = RESP;
          rsp_valid = 1'b1;
          rsp_rdata = is_store_op(op_q) ? '0 : align_rdata;
        end else if (wait_q == CW'(MAX_WAIT - 1)) begin
          state_d   = RESP;
          rsp_valid = 1'b1;
          rsp_err   = 1'b1;
        end else begin
          wait_d = wait_q + CW'(1);
        end
        if (state_d == RESP) begin
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_be_d    = '0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
        end
      end

      RESP: begin
        state_d = IDLE;
        wait_d  = '0;
      end

      default: state_d = IDLE;
    endcase

    // The response is steered to whichever requester owns the access being retired.
    if (rsp_valid) begin
      if (ls_owner_d) begin
        ls_ack_d   = 1'b1;
        ls_err_d   = rsp_err;
        ls_rdata_d = rsp_rdata;
      end else begin
        if_ack_d   = 1'b1;
        if_err_d   = rsp_err;
        if_rdata_d = rsp_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wait_q     <= '0;
      ls_owner_q <= 1'b0;
      op_q       <= LW_OP;
      lane_q     <= 2'b00;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_ack     <= 1'b0;
      if_err     <= 1'b0;
      if_rdata   <= '0;
      ls_ack     <= 1'b0;
      ls_err     <= 1'b0;
      ls_rdata   <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      ls_owner_q <= ls_owner_d;
      op_q       <= op_d;
      lane_q     <= lane_d;
      mem_req    <= mem_req_d;
      mem_we     <= mem_we_d;
      mem_be     <= mem_be_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      if_ack     <= if_ack_d;
      if_err     <= if_err_d;
      if_rdata   <= if_rdata_d;
      ls_ack     <= ls_ack_d;
      ls_err     <= ls_err_d;
      ls_rdata   <= ls_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level model sets per-cycle
// expectations that a single compare process checks on every falling edge.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int MAXW = 4;

  logic        clk, rst_n;
  logic        if_req, if_ack, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req, ls_ack, ls_err;
  alu_op_t     ls_op;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        stall;

  mem_arbiter #(.MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_err(if_err),
    .ls_req(ls_req), .ls_op(ls_op), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_rdata(ls_rdata), .ls_ack(ls_ack), .ls_err(ls_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  logic        exp_mem_req, exp_we, exp_if_ack, exp_ls_ack, exp_err, exp_stall, exp_chk_rdata;
  logic [3:0]  exp_be;
  logic [31:0] exp_addr, exp_wdata, exp_rdata;

  int          req_cycles = 0, ls_ack_cnt = 0, if_ack_cnt = 0;
  logic [31:0] cap_addr, cap_wdata, cap_ls_rdata;
  logic [3:0]  cap_be;
  logic        cap_we, cap_ls_err;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearExp();
    exp_mem_req   = 1'b0;
    exp_we        = 1'b0;
    exp_be        = 4'h0;
    exp_addr      = '0;
    exp_wdata     = '0;
    exp_if_ack    = 1'b0;
    exp_ls_ack    = 1'b0;
    exp_err       = 1'b0;
    exp_rdata     = '0;
    exp_chk_rdata = 1'b0;
  endtask

  // Transaction-level rules: legality, lane enables and returned data.
  function automatic bit modelLegal(bit use_ls, alu_op_t op, logic [31:0] addr);
    if (!use_ls) return addr[1:0] == 2'b00;
    if (op == LB_OP || op == SB_OP) return 1'b1;
    if (op == LW_OP || op == SW_OP) return addr[1:0] == 2'b00;
    return 1'b0;
  endfunction

  function automatic logic [3:0] modelBe(bit use_ls, alu_op_t op, logic [31:0] addr);
    if (use_ls && (op == LB_OP || op == SB_OP)) return 4'b0001 << addr[1:0];
    return 4'b1111;
  endfunction

  function automatic logic [31:0] modelRdata(bit use_ls, alu_op_t op, logic [31:0] addr, logic [31:0] raw);
    logic [7:0] b;
    if (!use_ls || op == LW_OP) return raw;
    b = 8'(raw >> (8 * addr[1:0]));
    return {{24{b[7]}}, b};
  endfunction

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("mem_req", 32'(mem_req), 32'(exp_mem_req));
      if (exp_mem_req) begin
        checkOutput("mem_addr", mem_addr, exp_addr);
        checkOutput("mem_be", 32'(mem_be), 32'(exp_be));
        checkOutput("mem_we", 32'(mem_we), 32'(exp_we));
        if (exp_we) checkOutput("mem_wdata", mem_wdata, exp_wdata);
      end
      checkOutput("if_ack", 32'(if_ack), 32'(exp_if_ack));
      checkOutput("ls_ack", 32'(ls_ack), 32'(exp_ls_ack));
      if (exp_if_ack) begin
        checkOutput("if_err", 32'(if_err), 32'(exp_err));
        if (exp_chk_rdata) checkOutput("if_rdata", if_rdata, exp_rdata);
      end
      if (exp_ls_ack) begin
        checkOutput("ls_err", 32'(ls_err), 32'(exp_err));
        if (exp_chk_rdata) checkOutput("ls_rdata", ls_rdata, exp_rdata);
      end
      checkOutput("stall", 32'(stall), 32'(exp_stall));
    end
    if (mem_req) begin
      req_cycles++;
      cap_addr  = mem_addr;
      cap_be    = mem_be;
      cap_we    = mem_we;
      cap_wdata = mem_wdata;
    end
    if (ls_ack) begin
      ls_ack_cnt++;
      cap_ls_rdata = ls_rdata;
      cap_ls_err   = ls_err;
    end
    if (if_ack) if_ack_cnt++;
  end

  // One complete access from a single requester; mem_ack arrives after ack_delay
  // mem_req cycles, and a delay of MAXW or more means no ack at all.
  task automatic applyStimulus(input bit use_ls, input alu_op_t op, input logic [31:0] addr,
                               input logic [31:0] wdata, input int ack_delay, input logic [31:0] raw);
    bit legal, err;
    legal = modelLegal(use_ls, op, addr);
    if (use_ls) begin
      ls_req = 1'b1; ls_op = op; ls_addr = addr; ls_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    clearExp();
    exp_stall = 1'b1;
    tick();
    if (legal) begin
      for (int n = 0; n < MAXW; n++) begin
        exp_mem_req = 1'b1;
        exp_addr    = {addr[31:2], 2'b00};
        exp_be      = modelBe(use_ls, op, addr);
        exp_we      = use_ls && (op == SW_OP || op == SB_OP);
        exp_wdata   = (op == SB_OP) ? {4{wdata[7:0]}} : wdata;
        mem_ack     = (n == ack_delay);
        mem_rdata   = (n == ack_delay) ? raw : 32'h5A5A_5A5A;
        tick();
        if (n == ack_delay) break;
      end
      mem_ack = 1'b0;
    end
    err = !legal || (ack_delay >= MAXW);
    clearExp();
    exp_stall     = 1'b0;
    exp_err       = err;
    exp_rdata     = err ? 32'h0 : modelRdata(use_ls, op, addr, raw);
    exp_chk_rdata = err || !(use_ls && (op == SW_OP || op == SB_OP));
    if (use_ls) exp_ls_ack = 1'b1;
    else        exp_if_ack = 1'b1;
    tick();
    ls_req = 1'b0;
    if_req = 1'b0;
    clearExp();
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_op = LW_OP;
    ls_addr = '0; ls_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
    clearExp();
    exp_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_mem_req", 32'(mem_req), 32'h0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'h0);
    checkOutput("rst_mem_be", 32'(mem_be), 32'h0);
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
    checkOutput("rst_if_ack", 32'(if_ack), 32'h0);
    checkOutput("rst_ls_ack", 32'(ls_ack), 32'h0);
    checkOutput("rst_if_err", 32'(if_err), 32'h0);
    checkOutput("rst_ls_err", 32'(ls_err), 32'h0);
    checkOutput("rst_if_rdata", if_rdata, 32'h0);
    checkOutput("rst_ls_rdata", ls_rdata, 32'h0);
    checkOutput("rst_stall", 32'(stall), 32'h0);
    rst_n = 1'b1;
    check_en = 1'b1;
    tick();

    base = ls_ack_cnt;
    applyStimulus(1'b1, LW_OP, 32'h0000_0100, 32'h0, 2, 32'hDEAD_BEEF);
    checkOutput("lw_ack_count", 32'(ls_ack_cnt - base), 32'd1);
    checkOutput("lw_rdata_lit", cap_ls_rdata, 32'hDEAD_BEEF);
    checkOutput("lw_err_lit", 32'(cap_ls_err), 32'h0);
    checkOutput("lw_be_lit", 32'(cap_be), 32'hF);
    checkOutput("lw_we_lit", 32'(cap_we), 32'h0);

    applyStimulus(1'b1, LB_OP, 32'h0000_0103, 32'h0, 0, 32'h80FF_1234);
    checkOutput("lb_addr_lit", cap_addr, 32'h0000_0100);
    checkOutput("lb_be_lit", 32'(cap_be), 32'h8);
    checkOutput("lb_rdata_lit", cap_ls_rdata, 32'hFFFF_FF80);

    applyStimulus(1'b1, SB_OP, 32'h0000_0101, 32'h0000_00AB, 1, 32'h0);
    checkOutput("sb_we_lit", 32'(cap_we), 32'h1);
    checkOutput("sb_be_lit", 32'(cap_be), 32'h2);
    checkOutput("sb_wdata_lit", cap_wdata, 32'hABAB_ABAB);

    applyStimulus(1'b1, SW_OP, 32'h0000_0204, 32'h1234_5678, 0, 32'h0);
    applyStimulus(1'b1, LB_OP, 32'h0000_0342, 32'h0, 1, 32'h127F_5634);
    checkOutput("lb_pos_lit", cap_ls_rdata, 32'h0000_007F);
    applyStimulus(1'b0, LW_OP, 32'h0000_0040, 32'h0, 1, 32'h00C0_FFEE);

    base = req_cycles;
    applyStimulus(1'b1, LW_OP, 32'h0000_0102, 32'h0, 0, 32'h0);
    checkOutput("misalign_no_req", 32'(req_cycles - base), 32'd0);
    checkOutput("misalign_err_lit", 32'(cap_ls_err), 32'h1);
    applyStimulus(1'b0, LW_OP, 32'h0000_0006, 32'h0, 0, 32'h0);
    applyStimulus(1'b1, XOR_OP, 32'h0000_0100, 32'h0, 0, 32'h0);

    base = req_cycles;
    applyStimulus(1'b1, LW_OP, 32'h0000_0300, 32'h0, 100, 32'h0);
    checkOutput("abort_req_cycles", 32'(req_cycles - base), 32'd4);
    checkOutput("abort_err_lit", 32'(cap_ls_err), 32'h1);
    base = ls_ack_cnt;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    repeat (3) tick();
    checkOutput("late_ack_ignored", 32'(ls_ack_cnt - base), 32'd0);

    // Simultaneous requests: load/store is served first, fetch stalls until its own ack.
    if_req = 1'b1; if_addr = 32'h0; ls_req = 1'b1; ls_op = LW_OP; ls_addr = 32'h0000_0200;
    clearExp(); exp_stall = 1'b1;
    tick();
    exp_mem_req = 1'b1; exp_addr = 32'h0000_0200; exp_be = 4'hF;
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    tick();
    mem_ack = 1'b0;
    clearExp(); exp_ls_ack = 1'b1; exp_rdata = 32'h1111_2222; exp_chk_rdata = 1'b1;
    tick();
    ls_req = 1'b0;
    clearExp();
    tick();
    exp_mem_req = 1'b1; exp_addr = 32'h0; exp_be = 4'hF;
    mem_ack = 1'b1; mem_rdata = 32'h3333_4444;
    tick();
    mem_ack = 1'b0;
    clearExp(); exp_if_ack = 1'b1; exp_rdata = 32'h3333_4444; exp_chk_rdata = 1'b1;
    exp_stall = 1'b0;
    tick();
    if_req = 1'b0;
    clearExp();
    tick();
    checkOutput("arb_if_last_addr", cap_addr, 32'h0);

    // Reset while an access is outstanding: it vanishes without a response.
    base = ls_ack_cnt;
    ls_req = 1'b1; ls_op = LW_OP; ls_addr = 32'h0000_0400;
    clearExp(); exp_stall = 1'b1;
    tick();
    exp_mem_req = 1'b1; exp_addr = 32'h0000_0400; exp_be = 4'hF;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_busy_mem_req", 32'(mem_req), 32'h0);
    ls_req = 1'b0;
    clearExp(); exp_stall = 1'b0;
    tick();
    rst_n = 1'b1;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    repeat (3) tick();
    checkOutput("rst_no_ls_ack", 32'(ls_ack_cnt - base), 32'd0);

    applyStimulus(1'b1, LW_OP, 32'h0000_0500, 32'h0, 0, 32'hCAFE_F00D);
    checkOutput("post_rst_rdata", cap_ls_rdata, 32'hCAFE_F00D);

    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
